// File: rtl/sdmf_frame_arbiter.sv
// Frame-granular round-robin arbiter: shares one SDMF sink among N_SRC sources,
// granting a whole frame (header strobe, beats to tlast) followed by one GAP cycle.
module sdmf_frame_arbiter #(
  parameter int N_SRC       = 4,
  parameter int SRC_W       = 2,
  parameter int FDSTI_WIDTH = 32,
  parameter int FDSSI_WIDTH = 2,
  parameter int DATA_WIDTH  = 24
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_SRC-1:0]               src_en,
  input  logic [N_SRC-1:0]               s_frame_valid,
  input  logic [N_SRC*FDSTI_WIDTH-1:0]   s_FDSTI,
  input  logic [N_SRC*FDSSI_WIDTH-1:0]   s_FDSSI,
  input  logic [N_SRC-1:0]               s_tvalid,
  output logic [N_SRC-1:0]               s_tready,
  input  logic [N_SRC-1:0]               s_tlast,
  input  logic [N_SRC*DATA_WIDTH-1:0]    s_tdata,
  output logic                           m_frame_valid,
  output logic                           m_FI_valid,
  output logic [FDSTI_WIDTH-1:0]         m_FDSTI,
  output logic [FDSSI_WIDTH-1:0]         m_FDSSI,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic                           m_tlast,
  output logic [DATA_WIDTH-1:0]          m_tdata,
  output logic [SRC_W-1:0]               grant_id,
  output logic                           abort_pulse,
  output logic [15:0]                    frame_cnt
);

  typedef enum logic [1:0] {IDLE, HDR, DATA, GAP} state_t;

  state_t                 state_q, state_d;
  logic [SRC_W-1:0]       grant_q, grant_d, rr_q, rr_d;
  logic [FDSTI_WIDTH-1:0] fdsti_q, fdsti_d;
  logic [FDSSI_WIDTH-1:0] fdssi_q, fdssi_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   abort_q, abort_d;
  logic                   fv_q, fi_q;

  logic [N_SRC-1:0]       req;
  logic                   pick_vld;
  logic [SRC_W-1:0]       pick_idx, sel;
  logic                   g_fv, g_tv, g_tl, last_hs, drop;
  logic [DATA_WIDTH-1:0]  g_td;

  assign req = s_frame_valid & src_en;

  // Search rr+1, rr+2, ... so the last granted source has lowest priority.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    sel      = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      sel = SRC_W'((int'(rr_q) + k) % N_SRC);
      if (!pick_vld && req[sel]) begin
        pick_vld = 1'b1;
        pick_idx = sel;
      end
    end
  end

  assign g_fv    = s_frame_valid[grant_q];
  assign g_tv    = s_tvalid[grant_q];
  assign g_tl    = s_tlast[grant_q];
  assign g_td    = s_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
  // A tlast handshake wins over a simultaneous frame_valid drop.
  assign last_hs = g_tv & m_tready & g_tl;
  assign drop    = ~g_fv & ~last_hs;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    fdsti_d  = fdsti_q;
    fdssi_d  = fdssi_q;
    cnt_d    = cnt_q;
    abort_d  = 1'b0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    m_tdata  = '0;
    s_tready = '0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = HDR;
          grant_d = pick_idx;
          rr_d    = pick_idx;
          fdsti_d = s_FDSTI[int'(pick_idx)*FDSTI_WIDTH +: FDSTI_WIDTH];
          fdssi_d = s_FDSSI[int'(pick_idx)*FDSSI_WIDTH +: FDSSI_WIDTH];
        end
      end
      HDR: state_d = DATA;
      DATA: begin
        m_tvalid          = g_tv & ~drop;
        m_tlast           = g_tl;
        m_tdata           = g_td;
        s_tready[grant_q] = m_tready & ~drop;
        if (last_hs) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = GAP;
        end else if (drop) begin
          abort_d = 1'b1;
          state_d = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= SRC_W'(N_SRC - 1);
      fdsti_q <= '0;
      fdssi_q <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      fv_q    <= 1'b0;
      fi_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      fdsti_q <= fdsti_d;
      fdssi_q <= fdssi_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      fv_q    <= (state_d == HDR) || (state_d == DATA);
      fi_q    <= (state_d == HDR);
    end
  end

  assign m_frame_valid = fv_q;
  assign m_FI_valid    = fi_q;
  assign m_FDSTI       = fdsti_q;
  assign m_FDSSI       = fdssi_q;
  assign grant_id      = grant_q;
  assign abort_pulse   = abort_q;
  assign frame_cnt     = cnt_q;

endmodule
